// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller: register map,
// FSM encoding and the status nibble returned during command bytes.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_LED     = 7'h00;
    localparam logic [6:0] ADDR_BUT     = 7'h01;
    localparam logic [6:0] ADDR_ID      = 7'h02;
    localparam logic [6:0] ADDR_SCRATCH = 7'h03;

    localparam logic [3:0] STATUS_NIBBLE = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Only LED and scratch accept writes; everything else is dropped.
    function automatic logic is_writable(input logic [6:0] addr);
        return (addr == ADDR_LED) || (addr == ADDR_SCRATCH);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser followed by registered rise/fall pulse
// generation. Pulses are one clk wide and aligned with each other.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchronise the pin and register the edge pulses off the synced level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            level_q <= sync_q[SYNC_STAGES-1];
            rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave register controller, fully in the clk_i domain.
// The SPI pins are oversampled; a command byte selects read/write and a
// 7-bit address, followed by a burst of data bytes with auto-increment.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       spi_sck_i,
    input  logic       spi_cs_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    input  logic [3:0] but_i,
    output logic [7:0] led_o,
    output logic       wr_stb_o,
    output logic [6:0] wr_addr_o
);

    logic sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (spi_sck_i),
        .rise_o  (sck_rise_s),
        .fall_o  (sck_fall_s)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (spi_cs_i),
        .rise_o  (cs_rise_s),
        .fall_o  (cs_fall_s)
    );

    // MOSI gets one extra stage so it lines up with the registered SCK pulse.
    logic [SYNC_STAGES:0]        mosi_sync_q;
    logic [SYNC_STAGES-1:0][3:0] but_sync_q;
    logic                        mosi_s;
    logic [3:0]                  but_s;

    // Plain synchronisers for MOSI and the push buttons.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mosi_sync_q <= '0;
            but_sync_q  <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-1:0], spi_mosi_i};
            but_sync_q  <= {but_sync_q[SYNC_STAGES-2:0], but_i};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES];
    assign but_s  = but_sync_q[SYNC_STAGES-1];

    state_e     state_q, state_d;
    logic       cs_act_q, cs_act_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] led_q, led_d;
    logic [7:0] scratch_q, scratch_d;
    logic       wr_stb_q;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic       miso_q, miso_d;

    logic       byte_done_s;
    logic [7:0] byte_s;
    logic       write_en_s;
    logic [6:0] rd_addr_s;
    logic [7:0] rd_data_s;

    // cs_act_q is still set during the cycle carrying cs_rise, which lets a
    // byte completing on that same cycle be committed before going idle.
    assign byte_s      = {rx_q[6:0], mosi_s};
    assign byte_done_s = cs_act_q & sck_rise_s & (cnt_q == 3'd7);

    // Chip-select level tracking, bit counter and receive shifter.
    always_comb begin
        cs_act_d = cs_act_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        if (cs_fall_s) begin
            cs_act_d = 1'b1;
        end else if (cs_rise_s) begin
            cs_act_d = 1'b0;
        end else begin
            cs_act_d = cs_act_q;
        end
        if (!cs_act_q) begin
            cnt_d = 3'd0;
        end else if (sck_rise_s) begin
            cnt_d = cnt_q + 3'd1;
            rx_d  = byte_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Read mux: CMD reads the freshly received address, DATA the next one.
    always_comb begin
        rd_addr_s = (state_q == ST_CMD) ? byte_s[6:0] : (addr_q + 7'd1);
        case (rd_addr_s)
            ADDR_LED:     rd_data_s = led_q;
            ADDR_BUT:     rd_data_s = {4'h0, but_s};
            ADDR_ID:      rd_data_s = ID_VALUE;
            ADDR_SCRATCH: rd_data_s = scratch_q;
            default:      rd_data_s = 8'h00;
        endcase
    end

    // Transaction FSM: next state, address/direction and transmit shifter.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        write_en_s = 1'b0;
        if (cs_act_q && sck_fall_s && (cnt_q != 3'd0)) begin
            tx_d = {tx_q[6:0], 1'b0};
        end else begin
            tx_d = tx_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d = ST_CMD;
                    tx_d    = {STATUS_NIBBLE, but_s};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (byte_done_s) begin
                    rw_d    = byte_s[7];
                    addr_d  = byte_s[6:0];
                    state_d = ST_DATA;
                    tx_d    = byte_s[7] ? 8'h00 : rd_data_s;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_DATA: begin
                if (byte_done_s) begin
                    write_en_s = rw_q & is_writable(addr_q);
                    addr_d     = addr_q + 7'd1;
                    tx_d       = rw_q ? 8'h00 : rd_data_s;
                end else begin
                    write_en_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (cs_rise_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Register file updates, write strobe address and MISO next value.
    always_comb begin
        led_d     = led_q;
        scratch_d = scratch_q;
        wr_addr_d = wr_addr_q;
        if (write_en_s) begin
            wr_addr_d = addr_q;
            if (addr_q == ADDR_LED) begin
                led_d = byte_s;
            end else begin
                scratch_d = byte_s;
            end
        end else begin
            wr_addr_d = wr_addr_q;
        end
        miso_d = cs_act_d ? tx_d[7] : 1'b0;
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cs_act_q  <= 1'b0;
            cnt_q     <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            rw_q      <= 1'b0;
            addr_q    <= 7'h00;
            led_q     <= 8'h00;
            scratch_q <= 8'h00;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 7'h00;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_act_q  <= cs_act_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
            wr_stb_q  <= write_en_s;
            wr_addr_q <= wr_addr_d;
            miso_q    <= miso_d;
        end
    end

    assign spi_miso_o = miso_q;
    assign led_o      = led_q;
    assign wr_stb_o   = wr_stb_q;
    assign wr_addr_o  = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed testbench for spi_reg_ctrl: drives SPI mode-0 transactions with
// SCK at 1/16 of clk and checks LED, MISO data and write strobes.
module tb_spi_reg_ctrl;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [3:0] but = 4'b0011;
    logic [7:0] led;
    logic       wr_stb;
    logic [6:0] wr_addr;

    int checks = 0;
    int failures = 0;
    int stb_total = 0;
    logic [6:0] stb_addr [0:63];

    spi_reg_ctrl #(.ID_VALUE(8'hA5), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .spi_sck_i  (sck),
        .spi_cs_i   (cs),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso),
        .but_i      (but),
        .led_o      (led),
        .wr_stb_o   (wr_stb),
        .wr_addr_o  (wr_addr)
    );

    always #5 clk = ~clk;

    // Record every write strobe and its address.
    always @(negedge clk) begin
        if (wr_stb) begin
            if (stb_total < 64) stb_addr[stb_total] <= wr_addr;
            stb_total <= stb_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift nbits of tx (MSB first), sampling MISO just before each rise.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            #HALF;
            rx[7-i] = miso;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        #HALF;
        cs = 1'b1;
        #(HALF*2);
    endtask

    logic [7:0] r0, r1, r2, r3, r4, r5;
    int base;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_led", {24'h0, led}, 32'h0);
        check("reset_miso", {31'h0, miso}, 32'h0);
        check("reset_stb", {31'h0, wr_stb}, 32'h0);
        check("reset_waddr", {25'h0, wr_addr}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write LED 0x5A; status byte is 0xA3 with buttons 0011.
        base = stb_total;
        cs_begin();
        spi_xfer(8'h80, 8, r0);
        spi_xfer(8'h5A, 8, r1);
        cs_end();
        check("wr_status", {24'h0, r0}, 32'hA3);
        check("wr_led", {24'h0, led}, 32'h5A);
        check("wr_stb_cnt", stb_total - base, 32'd1);
        check("wr_stb_addr", {25'h0, stb_addr[base]}, 32'h00);

        // Read ID.
        base = stb_total;
        cs_begin();
        spi_xfer(8'h02, 8, r0);
        spi_xfer(8'h00, 8, r1);
        cs_end();
        check("id_data", {24'h0, r1}, 32'hA5);
        check("id_led", {24'h0, led}, 32'h5A);
        check("id_stb_cnt", stb_total - base, 32'd0);

        // Burst write from 0x00: only LED and scratch accept data.
        base = stb_total;
        cs_begin();
        spi_xfer(8'h80, 8, r0);
        spi_xfer(8'h11, 8, r0);
        spi_xfer(8'h22, 8, r0);
        spi_xfer(8'h33, 8, r0);
        spi_xfer(8'h44, 8, r0);
        cs_end();
        check("burst_led", {24'h0, led}, 32'h11);
        check("burst_stb_cnt", stb_total - base, 32'd2);
        check("burst_stb0", {25'h0, stb_addr[base]}, 32'h00);
        check("burst_stb1", {25'h0, stb_addr[base+1]}, 32'h03);
        check("burst_waddr", {25'h0, wr_addr}, 32'h03);

        // Burst read from 0x00 through unmapped 0x04.
        cs_begin();
        spi_xfer(8'h00, 8, r0);
        spi_xfer(8'h00, 8, r1);
        spi_xfer(8'h00, 8, r2);
        spi_xfer(8'h00, 8, r3);
        spi_xfer(8'h00, 8, r4);
        spi_xfer(8'h00, 8, r5);
        cs_end();
        check("rd_led", {24'h0, r1}, 32'h11);
        check("rd_but", {24'h0, r2}, 32'h03);
        check("rd_id", {24'h0, r3}, 32'hA5);
        check("rd_scratch", {24'h0, r4}, 32'h44);
        check("rd_unmapped", {24'h0, r5}, 32'h00);

        // Button read with 1010 held.
        but = 4'b1010;
        #(HALF*2);
        cs_begin();
        spi_xfer(8'h01, 8, r0);
        spi_xfer(8'h00, 8, r1);
        cs_end();
        check("btn_status", {24'h0, r0}, 32'hAA);
        check("btn_data", {24'h0, r1}, 32'h0A);

        // Abort after 5 data bits, then a full write of 0xFF.
        base = stb_total;
        cs_begin();
        spi_xfer(8'h80, 8, r0);
        spi_xfer(8'hFF, 5, r0);
        cs_end();
        check("abort_led", {24'h0, led}, 32'h11);
        check("abort_stb_cnt", stb_total - base, 32'd0);
        cs_begin();
        spi_xfer(8'h80, 8, r0);
        spi_xfer(8'hFF, 8, r0);
        cs_end();
        check("after_abort_led", {24'h0, led}, 32'hFF);

        // Address wrap: write at 0x7F is dropped, next byte lands in LED.
        base = stb_total;
        cs_begin();
        spi_xfer(8'hFF, 8, r0);
        spi_xfer(8'hEE, 8, r0);
        spi_xfer(8'h77, 8, r0);
        cs_end();
        check("wrap_led", {24'h0, led}, 32'h77);
        check("wrap_stb_cnt", stb_total - base, 32'd1);
        check("wrap_stb_addr", {25'h0, stb_addr[base]}, 32'h00);

        // CS rises together with the 8th SCK rise: byte still committed.
        base = stb_total;
        cs_begin();
        spi_xfer(8'h80, 8, r0);
        spi_xfer(8'hC3, 7, r0);
        mosi = 1'b1;
        #HALF;
        sck = 1'b1;
        cs = 1'b1;
        #HALF;
        sck = 1'b0;
        #(HALF*2);
        check("coinc_led", {24'h0, led}, 32'hC3);
        check("coinc_stb_cnt", stb_total - base, 32'd1);

        // Reset after 4 data bits of a read-back-free write.
        cs_begin();
        spi_xfer(8'h80, 8, r0);
        spi_xfer(8'h81, 4, r0);
        rst_n = 1'b0;
        #1;
        check("rst_led", {24'h0, led}, 32'h00);
        check("rst_miso", {31'h0, miso}, 32'h0);
        cs = 1'b1;
        #(HALF*2);
        rst_n = 1'b1;
        #(HALF*2);
        cs_begin();
        spi_xfer(8'h80, 8, r0);
        spi_xfer(8'h81, 8, r0);
        cs_end();
        check("post_rst_led", {24'h0, led}, 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
